filter_decim_out: RTL and testbench
===================================

# filter_decim_out

Post-processing stage placed directly downstream of the order-2 FIR filter. It consumes the filter's 16-bit signed output and overflow flag, block-averages (decimates) 2^DECIM_LOG2 valid samples, saturates each mean to OUT_W bits and tags it with a quality flag. Results are buffered in a small FIFO behind a valid/ready handshake, and the block keeps saturating counters of overflow events and dropped results.

## Interface
- DECIM_LOG2, 2: log2 of the decimation factor N; N = 4 by default; legal range 1..4.
- OUT_W, 8: output sample width in bits, signed; legal range 2..16.
- DEPTH, 4: FIFO entries; power of two, minimum 2.

- clk  input  1  single clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- data_in  input  16  signed sample from the filter's data_out.
- overflow_in  input  1  filter's overflow_detected, qualified by in_valid.
- in_valid  input  1  data_in/overflow_in are a valid sample this cycle. There is no backpressure upstream.
- out_data  output  OUT_W  signed decimated sample at FIFO head.
- out_flag  output  1  head sample was saturated or its window contained an overflow.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  consumer accepts the head this cycle.
- ovf_count  output  16  count of cycles with in_valid & overflow_in; saturates at 0xFFFF.
- drop_count  output  8  count of results lost to a full FIFO; saturates at 0xFF.

## Operation
- Accumulator: signed, width 16+DECIM_LOG2. Sample counter: DECIM_LOG2 bits. Window overflow bit: win_ovf.
- When in_valid is high and the counter is below N-1:
  - acc += sign-extended data_in.
  - Counter increments.
  - win_ovf |= overflow_in.
- When in_valid is high and the counter equals N-1 (window end):
  - sum = acc + data_in.
  - mean = sum >>> DECIM_LOG2. This is an arithmetic shift, so the result is floored toward minus infinity.
  - Saturate mean to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; sat = 1 if clipping occurred.
  - Push {flag = sat | win_ovf | overflow_in, value} into the FIFO.
  - In the same cycle, acc, the counter and win_ovf clear to 0.
- Cycles with in_valid low change nothing in the accumulator path.
- FIFO behaviour:
  - First-word fall-through: out_data and out_flag show the head whenever out_valid is high.
  - A pop occurs when out_valid & out_ready.
  - out_data and out_flag stay stable while out_valid & !out_ready.
- Push onto a full FIFO:
  - If a pop occurs in the same cycle, both the pop and the push complete and the occupancy is unchanged.
  - Otherwise the new result is discarded, drop_count increments (saturating), and FIFO contents are untouched.
- Push onto an empty FIFO with out_ready high: the entry is written and becomes the head. It cannot be popped in its push cycle because out_valid was 0.
- ovf_count increments on every cycle with in_valid & overflow_in, independent of the window position.
- Both counters hold at their maximum and never wrap.

## Timing
- Reset (asynchronous, active-high) forces the following to 0 immediately and holds them while rst is high:
  - out_data, out_flag, out_valid;
  - ovf_count, drop_count;
  - accumulator, sample counter, win_ovf;
  - FIFO pointers and occupancy.
- Reset in mid-window discards the partial window. The first valid sample after release starts a new window.
- Latency: if the window-end sample is sampled at edge k and the FIFO was empty, out_valid is high from just after edge k. This is one cycle of latency.
- Throughput: one result per N valid inputs. The FIFO drains at one entry per cycle while out_ready is high.
- Counters update on the same edge as the event that increments them.

## Test plan
- Averaging:
  - Stimulus: in_valid with 10, 20, 30, 40; out_ready = 1.
  - Required: one result with out_data = 25, out_flag = 0, out_valid high for exactly one cycle.
- Floor rounding:
  - Stimulus: -1, -1, -1, -2 (sum -5).
  - Required: out_data = -2, out_flag = 0.
- Saturation:
  - Stimulus: four samples of 1000, then four samples of -1000.
  - Required: out_data = 127 with out_flag = 1, then out_data = -128 with out_flag = 1.
- Overflow tagging:
  - Stimulus: four samples of 0, overflow_in = 1 on the 2nd only.
  - Required: out_data = 0, out_flag = 1, ovf_count = 1.
- Backpressure and drop:
  - Stimulus: out_ready = 0 while 5 windows (values 1..5 as means) complete.
  - Required: out_valid high with out_data = 1 stable throughout, drop_count = 1. Then raise out_ready: out_data shows 1, 2, 3, 4 on consecutive cycles, then out_valid = 0.
  - Additional case: a window completes in the same cycle as a pop from a full FIFO. Required: no drop, and the entry is accepted.
- Reset mid-window:
  - Stimulus: samples 100, 100, assert rst for one cycle, then samples 4, 8, 12, 16.
  - Required: all outputs 0 during reset; the single result afterwards is out_data = 10.

Source files
------------

// File: rtl/filter_decim_out.sv
// filter_decim_out: block-averages 2^DECIM_LOG2 filter samples, saturates to OUT_W bits,
// and queues flagged results in a first-word-fall-through FIFO with overflow/drop counters.
module filter_decim_out #(
   parameter int DECIM_LOG2 = 2,
   parameter int OUT_W = 8,
   parameter int DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [15:0]       data_in,
   input  logic              overflow_in,
   input  logic              in_valid,
   output logic [OUT_W-1:0]  out_data,
   output logic              out_flag,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [15:0]       ovf_count,
   output logic [7:0]        drop_count
);
   localparam int AW = 16 + DECIM_LOG2;
   localparam int PW = $clog2(DEPTH);
   localparam logic signed [AW-1:0] s_max = AW'((1 << (OUT_W - 1)) - 1);
   localparam logic signed [AW-1:0] s_min = ~s_max;

   logic signed [AW-1:0] acc, sum, mean;
   logic [DECIM_LOG2-1:0] cnt;
   logic win_ovf, win_end, sat, pop, full, push, drop;
   logic [OUT_W-1:0] value;
   logic [OUT_W:0] mem [DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [PW:0] occ;

   assign win_end = in_valid & (&cnt);
   assign sum = acc + {{DECIM_LOG2{data_in[15]}}, data_in};
   // arithmetic shift floors the mean toward minus infinity
   assign mean = sum >>> DECIM_LOG2;
   assign sat = (mean > s_max) || (mean < s_min);
   assign value = mean > s_max ? s_max[OUT_W-1:0] : mean < s_min ? s_min[OUT_W-1:0] : mean[OUT_W-1:0];
   assign out_valid = occ != '0;
   assign full = occ == (PW+1)'(DEPTH);
   assign pop = out_valid & out_ready;
   assign push = win_end & (~full | pop);
   assign drop = win_end & full & ~pop;
   // gating by out_valid keeps the outputs at zero through and after reset
   assign {out_flag, out_data} = out_valid ? mem[rd_ptr] : '0;

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         acc <= '0;
         cnt <= '0;
         win_ovf <= 1'b0;
      end else if (in_valid) begin
         acc <= win_end ? '0 : sum;
         cnt <= cnt + DECIM_LOG2'(1);
         win_ovf <= ~win_end & (win_ovf | overflow_in);
      end

   always_ff @(posedge clk)
      if (push) mem[wr_ptr] <= {sat | win_ovf | overflow_in, value};

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop) rd_ptr <= rd_ptr + PW'(1);
         occ <= occ + (PW+1)'(push) - (PW+1)'(pop);
      end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         ovf_count <= '0;
         drop_count <= '0;
      end else begin
         if (in_valid & overflow_in & ~&ovf_count) ovf_count <= ovf_count + 16'd1;
         if (drop & ~&drop_count) drop_count <= drop_count + 8'd1;
      end
endmodule

// File: tb/tb_filter_decim_out.sv
// tb_filter_decim_out: directed vectors with hand-computed results for the default
// configuration (N = 4, OUT_W = 8, DEPTH = 4).
module tb_filter_decim_out;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [15:0] data_in = '0;
   logic overflow_in = 1'b0;
   logic in_valid = 1'b0;
   logic [7:0] out_data;
   logic out_flag, out_valid;
   logic out_ready = 1'b1;
   logic [15:0] ovf_count;
   logic [7:0] drop_count;
   int checks = 0;
   int passed = 0;

   filter_decim_out dut (
      .clk(clk), .rst(rst), .data_in(data_in), .overflow_in(overflow_in),
      .in_valid(in_valid), .out_data(out_data), .out_flag(out_flag),
      .out_valid(out_valid), .out_ready(out_ready), .ovf_count(ovf_count),
      .drop_count(drop_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got == exp) passed++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int v, input bit ov);
      data_in = 16'(v);
      overflow_in = ov;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      overflow_in = 1'b0;
   endtask

   task automatic window(input int v);
      for (int i = 0; i < 4; i++) send(v, 1'b0);
   endtask

   task automatic head(input string tag, input int d, input int f);
      chk({tag, " valid"}, int'(out_valid), 1);
      chk({tag, " data"}, int'($signed(out_data)), d);
      chk({tag, " flag"}, int'(out_flag), f);
   endtask

   task automatic zeros(input string tag);
      chk({tag, " valid"}, int'(out_valid), 0);
      chk({tag, " data"}, int'(out_data), 0);
      chk({tag, " flag"}, int'(out_flag), 0);
      chk({tag, " ovf_count"}, int'(ovf_count), 0);
      chk({tag, " drop_count"}, int'(drop_count), 0);
   endtask

   initial begin
      tick();
      tick();
      zeros("reset");
      rst = 1'b0;
      tick();
      send(10, 0);
      send(20, 0);
      send(30, 0);
      chk("avg early valid", int'(out_valid), 0);
      send(40, 0);
      head("avg", 25, 0);
      tick();
      chk("avg one cycle", int'(out_valid), 0);
      send(-1, 0);
      send(-1, 0);
      send(-1, 0);
      send(-2, 0);
      head("floor", -2, 0);
      tick();
      window(1000);
      head("sat hi", 127, 1);
      tick();
      window(-1000);
      head("sat lo", -128, 1);
      tick();
      chk("ovf before", int'(ovf_count), 0);
      send(0, 0);
      send(0, 1);
      send(0, 0);
      send(0, 0);
      head("ovf tag", 0, 1);
      chk("ovf count", int'(ovf_count), 1);
      tick();
      out_ready = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         window(k);
         head($sformatf("bp hold %0d", k), 1, 0);
      end
      chk("drop count", int'(drop_count), 1);
      out_ready = 1'b1;
      chk("drain 1", int'($signed(out_data)), 1);
      for (int k = 2; k <= 4; k++) begin
         tick();
         head($sformatf("drain %0d", k), k, 0);
      end
      tick();
      chk("drain empty", int'(out_valid), 0);
      out_ready = 1'b0;
      for (int k = 1; k <= 4; k++) window(k);
      send(5, 0);
      send(5, 0);
      send(5, 0);
      out_ready = 1'b1;
      send(5, 0);
      chk("full+pop no drop", int'(drop_count), 1);
      head("full+pop head", 2, 0);
      for (int k = 3; k <= 5; k++) begin
         tick();
         head($sformatf("full+pop drain %0d", k), k, 0);
      end
      tick();
      chk("full+pop empty", int'(out_valid), 0);
      out_ready = 1'b0;
      window(7);
      head("pending", 7, 0);
      send(100, 0);
      send(100, 0);
      rst = 1'b1;
      #1;
      zeros("mid reset");
      tick();
      zeros("reset held");
      rst = 1'b0;
      out_ready = 1'b1;
      send(4, 0);
      send(8, 0);
      tick();
      send(12, 0);
      chk("post reset early", int'(out_valid), 0);
      send(16, 0);
      head("post reset", 10, 0);
      tick();
      chk("post reset empty", int'(out_valid), 0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
